timer_sequencer: RTL

Programmable duration sequencer that sits directly upstream of the Timer block. It holds a small table of 16-bit segment lengths. On command it drives the Timer's `n_i` and `start_i` through each segment in order, waiting for `curr_end_q` before moving on. It reports per-segment and end-of-sequence events, can loop, and can be aborted at any time.

---
 rtl/timer_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/timer_sequencer.sv
// Duration sequencer feeding a Timer: steps through a table of segment lengths,
// driving n/start and waiting for the Timer's end flag between segments.
module timer_sequencer #(
   parameter  int DEPTH = 8,
   parameter  int W     = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic [AW:0]   len_i,
   input  logic          loop_i,
   input  logic          go_i,
   input  logic          abort_i,
   input  logic          tmr_end_i,
   output logic          tmr_start_o,
   output logic [W-1:0]  tmr_n_o,
   output logic [AW-1:0] seg_idx_o,
   output logic          busy_o,
   output logic          seg_done_o,
   output logic          seq_done_o
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CLR, S_NEXT} state_t;

   state_t        state_q;
   logic [W-1:0]  tbl_q [DEPTH];
   logic [AW-1:0] idx_q;
   logic [AW:0]   len_q;
   logic [W-1:0]  n_q;
   logic          start_q;
   logic          seg_done_q;
   logic          seq_done_q;

   logic          len_ok;
   logic          last_seg;
   logic [W-1:0]  entry;

   assign len_ok   = (len_i != '0) && (len_i <= (AW+1)'(DEPTH));
   assign last_seg = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
   assign entry    = tbl_q[idx_q];

   // Table is writable in every state; a LOAD reads the pre-edge contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      end else if (wr_en_i) begin
         tbl_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         len_q      <= '0;
         n_q        <= '0;
         start_q    <= 1'b0;
         seg_done_q <= 1'b0;
         seq_done_q <= 1'b0;
      end else begin
         seg_done_q <= 1'b0;
         seq_done_q <= 1'b0;
         // Abort wins over every other transition and suppresses done pulses.
         if (abort_i && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (go_i && len_ok) begin
                     len_q   <= len_i;
                     idx_q   <= '0;
                     state_q <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  n_q <= entry;
                  if (entry != '0) begin
                     start_q <= 1'b1;
                     state_q <= S_RUN;
                  end else begin
                     seg_done_q <= 1'b1;
                     state_q    <= S_NEXT;
                  end
               end
               S_RUN: begin
                  if (tmr_end_i) begin
                     start_q    <= 1'b0;
                     seg_done_q <= 1'b1;
                     state_q    <= S_CLR;
                  end
               end
               S_CLR: begin
                  if (!tmr_end_i) state_q <= S_NEXT;
               end
               S_NEXT: begin
                  if (!last_seg) begin
                     idx_q   <= idx_q + AW'(1);
                     state_q <= S_LOAD;
                  end else if (loop_i) begin
                     idx_q   <= '0;
                     state_q <= S_LOAD;
                  end else begin
                     seq_done_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign tmr_start_o = start_q;
   assign tmr_n_o     = n_q;
   assign seg_idx_o   = idx_q;
   assign busy_o      = (state_q != S_IDLE);
   assign seg_done_o  = seg_done_q;
   assign seq_done_o  = seq_done_q;

endmodule
